// File: rtl/shift_deser_if.sv
// Word output port of the serial deserialiser: a single valid/ready channel.
interface shift_deser_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;

   modport master (
      output dout,
      output dout_valid,
      input  dout_ready
   );

   modport slave (
      input  dout,
      input  dout_valid,
      output dout_ready
   );
endinterface

// File: rtl/shift_deser.sv
// Serial-in / parallel-out word receiver with MSB- or LSB-first framing,
// a single-entry valid/ready output register and sticky overrun detection.
module shift_deser #(
   parameter int unsigned WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          dir,
   input  logic          sin,
   input  logic          bit_en,
   input  logic          clr,
   output logic          busy,
   output logic          overrun,
   shift_deser_if.master dport
);
   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e             state_q;
   logic [CntW-1:0]    cnt_q;
   logic [WIDTH-1:0]   sreg_q;
   logic               dir_q;
   logic [WIDTH-1:0]   dout_q;
   logic               valid_q;
   logic               busy_q;
   logic               ovr_q;

   logic [WIDTH-1:0]   shift_next;
   logic               last_bit;
   logic               take;

   always_comb begin
      shift_next = dir_q ? {sin, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], sin};
      last_bit   = (state_q == StShift) && !start && bit_en && (cnt_q == LastCnt);
      // Holding register can accept a new word if empty or being drained this edge.
      take       = !valid_q || dport.dout_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sreg_q  <= '0;
         dir_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (clr) ovr_q <= 1'b0;
         if (valid_q && dport.dout_ready) valid_q <= 1'b0;

         // Later assignments win: a fresh word overrides the drain, a drop overrides clr.
         if (last_bit) begin
            if (take) begin
               dout_q  <= shift_next;
               valid_q <= 1'b1;
            end else begin
               ovr_q   <= 1'b1;
            end
         end

         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StShift;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  sreg_q  <= '0;
                  dir_q   <= dir;
               end
            end
            StShift: begin
               if (start) begin
                  cnt_q  <= '0;
                  sreg_q <= '0;
                  dir_q  <= dir;
               end else if (bit_en) begin
                  sreg_q <= shift_next;
                  if (cnt_q == LastCnt) begin
                     cnt_q   <= '0;
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dport.dout       = dout_q;
   assign dport.dout_valid = valid_q;
   assign busy             = busy_q;
   assign overrun          = ovr_q;

endmodule
